// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU global-buffer loader.
package tpu_pkg;

  localparam int DATA_W = 8;
  localparam int WORD_W = 32;
  localparam int IDX_W  = 16;
  localparam int DIM_W  = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    LAUNCH  = 3'd3,
    WAIT_HI = 3'd4,
    WAIT_LO = 3'd5
  } loader_state_t;

endpackage

// File: rtl/tpu_gbuf_loader_byte_packer.sv
// byte_packer: gathers four bytes into one 32-bit word, first byte in the
// most significant lane. word_valid fires combinationally with the 4th byte,
// and word_data is valid in that same cycle.
module byte_packer
  import tpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  localparam int SH_W = WORD_W - DATA_W;

  logic [1:0]      r_cnt;
  logic [SH_W-1:0] r_shift;

  // Shift in accepted bytes; the counter wraps every four bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (clear) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (byte_valid) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {r_shift[SH_W-DATA_W-1:0], byte_data};
    end
  end

  assign word_valid = byte_valid && (r_cnt == 2'd3);
  assign word_data  = {r_shift, byte_data};

endmodule

// File: rtl/tpu_gbuf_loader.sv
// tpu_gbuf_loader: packs an int8 byte stream into buffer A then buffer B,
// launches the TPU and waits for its busy pulse to complete.
// Optional build macro TPU_LOADER_CHECKSUM_EN adds a 16-bit byte-sum output.
//
// state   | meaning
// IDLE    | waiting for start; rejects zero dimensions with err
// LOAD_A  | streaming bytes into buffer A words 0..nA-1
// LOAD_B  | streaming bytes into buffer B words 0..nB-1
// LAUNCH  | in_valid high for one cycle with latched K/M/N
// WAIT_HI | waiting for the TPU to raise busy
// WAIT_LO | waiting for busy to fall, then done
module tpu_gbuf_loader
  import tpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_K,
  input  logic [DIM_W-1:0]  cfg_M,
  input  logic [DIM_W-1:0]  cfg_N,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              A_wr_en,
  output logic [IDX_W-1:0]  A_index,
  output logic [WORD_W-1:0] A_data_in,
  output logic              B_wr_en,
  output logic [IDX_W-1:0]  B_index,
  output logic [WORD_W-1:0] B_data_in,
  output logic              in_valid,
  output logic [DIM_W-1:0]  K,
  output logic [DIM_W-1:0]  M,
  output logic [DIM_W-1:0]  N,
  input  logic              busy,
  output logic              idle,
  output logic              done,
  output logic              err,
  output logic [15:0]       checksum
);

  loader_state_t     r_state;
  logic [DIM_W-1:0]  r_k, r_m, r_n;
  logic [IDX_W-1:0]  r_wa, r_wb;

  logic              w_accept;
  logic              w_dims_ok;
  logic              w_start_ok;
  logic              w_word_valid;
  logic [WORD_W-1:0] w_word;
  logic [IDX_W-1:0]  w_na, w_nb;

  // Word counts are done in 16 bits so (dim+3) cannot wrap at 255.
  assign w_na = ((IDX_W'(r_m) + IDX_W'(3)) >> 2) * IDX_W'(r_k);
  assign w_nb = ((IDX_W'(r_n) + IDX_W'(3)) >> 2) * IDX_W'(r_k);

  assign w_dims_ok  = (cfg_K != '0) && (cfg_M != '0) && (cfg_N != '0);
  assign w_start_ok = (r_state == IDLE) && start && w_dims_ok;

  // s_ready follows the state directly, so it drops the cycle after the last
  // B byte and stays high across the A-to-B handover.
  assign s_ready  = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign w_accept = s_valid && s_ready;
  assign idle     = (r_state == IDLE);

  assign K = r_k;
  assign M = r_m;
  assign N = r_n;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (w_start_ok),
    .byte_valid (w_accept),
    .byte_data  (s_data),
    .word_valid (w_word_valid),
    .word_data  (w_word)
  );

  // Main sequencer with registered write ports and handshake pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_m       <= '0;
      r_n       <= '0;
      r_wa      <= '0;
      r_wb      <= '0;
      A_wr_en   <= 1'b0;
      A_index   <= '0;
      A_data_in <= '0;
      B_wr_en   <= 1'b0;
      B_index   <= '0;
      B_data_in <= '0;
      in_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      A_wr_en  <= 1'b0;
      B_wr_en  <= 1'b0;
      in_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (!w_dims_ok) begin
              err <= 1'b1;
            end else begin
              r_k     <= cfg_K;
              r_m     <= cfg_M;
              r_n     <= cfg_N;
              r_wa    <= '0;
              r_wb    <= '0;
              r_state <= LOAD_A;
            end
          end
        end
        LOAD_A: begin
          if (w_word_valid) begin
            A_wr_en   <= 1'b1;
            A_index   <= r_wa;
            A_data_in <= w_word;
            r_wa      <= r_wa + IDX_W'(1);
            if (r_wa == w_na - IDX_W'(1)) r_state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (w_word_valid) begin
            B_wr_en   <= 1'b1;
            B_index   <= r_wb;
            B_data_in <= w_word;
            r_wb      <= r_wb + IDX_W'(1);
            if (r_wb == w_nb - IDX_W'(1)) begin
              r_state  <= LAUNCH;
              in_valid <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          r_state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (busy) r_state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!busy) begin
            done    <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef TPU_LOADER_CHECKSUM_EN
  logic [15:0] r_checksum;

  // Running unsigned byte sum, restarted by each accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + {8'd0, s_data};
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_tpu_gbuf_loader.sv
// Self-checking bench for tpu_gbuf_loader: vector table, randomized jobs
// against a word-list reference model, and reset/restart sequences.
module tb_tpu_gbuf_loader;

  logic        clk, rst, start;
  logic [7:0]  cfg_K, cfg_M, cfg_N;
  logic        s_valid, s_ready;
  logic [7:0]  s_data;
  logic        A_wr_en, B_wr_en, in_valid, busy, idle, done, err;
  logic [15:0] A_index, B_index, checksum;
  logic [31:0] A_data_in, B_data_in;
  logic [7:0]  K, M, N;

  int n_checks = 0;
  int n_errors = 0;

  tpu_gbuf_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_K(cfg_K), .cfg_M(cfg_M), .cfg_N(cfg_N),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .A_wr_en(A_wr_en), .A_index(A_index), .A_data_in(A_data_in),
    .B_wr_en(B_wr_en), .B_index(B_index), .B_data_in(B_data_in),
    .in_valid(in_valid), .K(K), .M(M), .N(N),
    .busy(busy), .idle(idle), .done(done), .err(err), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write / launch monitor sampled on the falling edge.
  logic [47:0] qa[$];
  logic [47:0] qb[$];
  int          iv_cnt, iv_cyc;
  logic [23:0] iv_kmn;

  always @(negedge clk) begin
    if (A_wr_en) qa.push_back({A_index, A_data_in});
    if (B_wr_en) qb.push_back({B_index, B_data_in});
    if (in_valid) begin
      if (iv_cnt == 0) begin
        iv_cyc = cyc;
        iv_kmn = {K, M, N};
      end
      iv_cnt++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " ctrl"}, 64'({s_ready, A_wr_en, B_wr_en, in_valid, done, err, idle}), 64'(7'b0000001));
    check({tag, " idx"},  64'({A_index, B_index}), 64'(0));
    check({tag, " data"}, 64'({A_data_in, B_data_in}), 64'(0));
    check({tag, " kmn"},  64'({K, M, N, checksum}), 64'(0));
  endtask

  // Runs a whole job. gap: 0 none, 1 alternate, 2 random.
  // midstart re-issues start inside LOAD_B; rst_after >= 0 aborts with reset
  // after that many accepted bytes.
  task automatic run_job(input string tag, input int k, input int m, input int n,
                         input int gap, input bit pattern, input bit midstart,
                         input int rst_after);
    int na, nb, total, idx, budget, start_cyc, sum;
    bit tog;
    logic [7:0]  b[$];
    logic [31:0] w;
    na = ((m + 3) / 4) * k;
    nb = ((n + 3) / 4) * k;
    total = 4 * (na + nb);
    b = {};
    sum = 0;
    for (int i = 0; i < total; i++) begin
      b.push_back(pattern ? 8'(i) : 8'($urandom));
      sum += int'(b[i]);
    end

    @(negedge clk);
    qa = {};
    qb = {};
    iv_cnt = 0;
    start = 1'b1;
    cfg_K = 8'(k);
    cfg_M = 8'(m);
    cfg_N = 8'(n);
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    budget = 0;
    tog = 1'b0;
    while (idx < total && budget < 4000) begin
      if (rst_after >= 0 && idx == rst_after) begin
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_values({tag, " mid-reset"});
        rst = 1'b0;
        return;
      end
      case (gap)
        0: s_valid = 1'b1;
        1: begin s_valid = tog; tog = ~tog; end
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = b[idx];
      if (midstart && idx == 4 * na + 2) begin
        start = 1'b1;
        cfg_K = 8'd9; cfg_M = 8'd9; cfg_N = 8'd9;
      end else begin
        start = 1'b0;
      end
      if (s_valid && s_ready) idx++;
      @(negedge clk);
      budget++;
    end
    s_valid = 1'b0;
    start = 1'b0;
    check({tag, " stream complete"}, 64'(idx), 64'(total));
    check({tag, " s_ready low after last byte"}, 64'(s_ready), 64'(0));

    budget = 0;
    while (iv_cnt == 0 && budget < 5) begin
      @(negedge clk);
      budget++;
    end
    check({tag, " in_valid count"}, 64'(iv_cnt), 64'(1));
    check({tag, " launch KMN"}, 64'(iv_kmn), 64'({8'(k), 8'(m), 8'(n)}));
    if (gap == 0) check({tag, " launch latency"}, 64'(iv_cyc - start_cyc), 64'(total + 1));
    if (gap == 1) check({tag, " launch latency"}, 64'(iv_cyc - start_cyc), 64'(2 * total + 1));

    repeat (2) @(negedge clk);
    check({tag, " not idle while waiting"}, 64'({idle, done}), 64'(0));
    busy = 1'b1;
    repeat (10) @(negedge clk);
    check({tag, " no done during busy"}, 64'(done), 64'(0));
    busy = 1'b0;
    @(negedge clk);
    check({tag, " done pulse"}, 64'(done), 64'(1));
`ifdef TPU_LOADER_CHECKSUM_EN
    check({tag, " checksum"}, 64'(checksum), 64'(16'(sum)));
`else
    check({tag, " checksum"}, 64'(checksum), 64'(0));
`endif
    @(negedge clk);
    check({tag, " done one cycle / idle"}, 64'({done, idle}), 64'(2'b01));
    check({tag, " in_valid total"}, 64'(iv_cnt), 64'(1));

    check({tag, " A writes"}, 64'(qa.size()), 64'(na));
    check({tag, " B writes"}, 64'(qb.size()), 64'(nb));
    for (int i = 0; i < na && i < qa.size(); i++) begin
      w = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
      check({tag, " A word"}, 64'(qa[i]), 64'({16'(i), w}));
    end
    for (int i = 0; i < nb && i < qb.size(); i++) begin
      w = {b[4*(na+i)], b[4*(na+i)+1], b[4*(na+i)+2], b[4*(na+i)+3]};
      check({tag, " B word"}, 64'(qb[i]), 64'({16'(i), w}));
    end
  endtask

  task automatic run_err(input string tag, input int k, input int m, input int n);
    @(negedge clk);
    qa = {};
    qb = {};
    start = 1'b1;
    cfg_K = 8'(k);
    cfg_M = 8'(m);
    cfg_N = 8'(n);
    @(negedge clk);
    start = 1'b0;
    check({tag, " err/idle/s_ready"}, 64'({err, idle, s_ready}), 64'(3'b110));
    @(negedge clk);
    check({tag, " err one cycle"}, 64'(err), 64'(0));
    repeat (4) @(negedge clk);
    check({tag, " still idle no ready"}, 64'({idle, s_ready}), 64'(2'b10));
    check({tag, " no writes"}, 64'(qa.size() + qb.size()), 64'(0));
  endtask

  typedef struct {
    int k, m, n, gap;
    bit pattern;
    bit exp_err;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{4, 4, 4, 0, 1'b1, 1'b0};
    vt[1] = '{3, 5, 8, 0, 1'b0, 1'b0};
    vt[2] = '{0, 4, 4, 0, 1'b0, 1'b1};
    vt[3] = '{4, 4, 4, 1, 1'b1, 1'b0};
    vt[4] = '{1, 1, 1, 2, 1'b0, 1'b0};
    vt[5] = '{2, 7, 3, 2, 1'b0, 1'b0};
    vt[6] = '{4, 0, 1, 0, 1'b0, 1'b1};
    vt[7] = '{1, 2, 0, 0, 1'b0, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    cfg_K = '0; cfg_M = '0; cfg_N = '0;
    s_valid = 1'b0;
    s_data = '0;
    busy = 1'b0;
    iv_cnt = 0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (vt[i].exp_err) run_err($sformatf("vec%0d", i), vt[i].k, vt[i].m, vt[i].n);
      else run_job($sformatf("vec%0d", i), vt[i].k, vt[i].m, vt[i].n,
                   vt[i].gap, vt[i].pattern, 1'b0, -1);
    end

    for (int i = 0; i < 6; i++) begin
      run_job($sformatf("rand%0d", i), $urandom_range(1, 12), $urandom_range(1, 12),
              $urandom_range(1, 12), $urandom_range(0, 2), 1'b0, 1'b0, -1);
    end

    run_job("restart_in_B", 4, 4, 4, 0, 1'b0, 1'b1, -1);
    run_job("reset_mid_A", 4, 4, 4, 0, 1'b0, 1'b0, 6);
    run_job("after_reset", 4, 4, 4, 0, 1'b1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
